// File: rtl/i2s_receiver.sv
// Philips-I2S receiver: oversamples SCK/WS/SD in the clk domain and emits
// right-aligned left/right sample pairs with a one-cycle data_ready strobe.
module i2s_receiver #(
    parameter int SYNC_STAGES   = 2,
    parameter bit WS_LEFT_LEVEL = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  sample_size,
    input  logic        i2s_sck,
    input  logic        i2s_ws,
    input  logic        i2s_sd,
    output logic [31:0] sample_left,
    output logic [31:0] sample_right,
    output logic        data_ready,
    output logic        frame_error
);

    typedef enum logic [1:0] {HUNT, LEFT, RIGHT} state_t;

    function automatic logic [5:0] decode_width(input logic [2:0] size);
        case (size)
            3'd0:    decode_width = 6'd8;
            3'd1:    decode_width = 6'd12;
            3'd4:    decode_width = 6'd24;
            3'd5:    decode_width = 6'd32;
            default: decode_width = 6'd16;
        endcase
    endfunction

    function automatic logic [5:0] sat_inc(input logic [5:0] cnt);
        sat_inc = (cnt >= 6'd32) ? 6'd32 : cnt + 6'd1;
    endfunction

    logic [SYNC_STAGES-1:0] sck_sync_p0, ws_sync_p0, sd_sync_p0;
    logic        sck_prev_p1;
    logic        sck_s, ws_s, sd_s, sck_edge;
    logic        ws_prev;
    logic [5:0]  bit_cnt, cnt_next, n_lat;
    logic [31:0] shift_reg, sr_next, hold_left;
    logic        boundary, word_ok;
    state_t      state, state_next;

    assign sck_s    = sck_sync_p0[SYNC_STAGES-1];
    assign ws_s     = ws_sync_p0[SYNC_STAGES-1];
    assign sd_s     = sd_sync_p0[SYNC_STAGES-1];
    assign sck_edge = sck_s & ~sck_prev_p1;

    // Stage p0: pad synchronisers; stage p1: SCK edge history
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync_p0 <= '0;
            ws_sync_p0  <= '0;
            sd_sync_p0  <= '0;
            sck_prev_p1 <= 1'b0;
        end else begin
            sck_sync_p0 <= {sck_sync_p0[SYNC_STAGES-2:0], i2s_sck};
            ws_sync_p0  <= {ws_sync_p0[SYNC_STAGES-2:0], i2s_ws};
            sd_sync_p0  <= {sd_sync_p0[SYNC_STAGES-2:0], i2s_sd};
            sck_prev_p1 <= sck_s;
        end
    end

    // The boundary bit is folded into the word before the length check.
    assign boundary = sck_edge && (ws_s != ws_prev);
    assign cnt_next = sat_inc(bit_cnt);
    assign sr_next  = (bit_cnt < n_lat) ? {shift_reg[30:0], sd_s} : shift_reg;
    assign word_ok  = (cnt_next >= n_lat);

    always_ff @(posedge clk) begin
        if (rst) state <= HUNT;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (boundary) begin
            case (state)
                HUNT:    if (ws_s == WS_LEFT_LEVEL) state_next = LEFT;
                LEFT:    state_next = word_ok ? RIGHT : HUNT;
                RIGHT:   state_next = word_ok ? LEFT : HUNT;
                default: state_next = HUNT;
            endcase
        end
    end

    // Stage p2: word assembly and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ws_prev      <= 1'b0;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            n_lat        <= 6'd16;
            sample_left  <= '0;
            sample_right <= '0;
            data_ready   <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            data_ready <= 1'b0;
            if (sck_edge) begin
                ws_prev <= ws_s;
                if (boundary) begin
                    bit_cnt   <= '0;
                    shift_reg <= '0;
                    case (state)
                        HUNT: begin
                            if (ws_s == WS_LEFT_LEVEL) n_lat <= decode_width(sample_size);
                        end
                        LEFT: begin
                            if (!word_ok) frame_error <= 1'b1;
                        end
                        RIGHT: begin
                            if (word_ok) begin
                                sample_left  <= hold_left;
                                sample_right <= sr_next;
                                data_ready   <= 1'b1;
                                n_lat        <= decode_width(sample_size);
                            end else begin
                                frame_error <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end else begin
                    bit_cnt   <= cnt_next;
                    shift_reg <= sr_next;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (sck_edge && boundary && state == LEFT && word_ok) hold_left <= sr_next;
    end

endmodule

// File: tb/tb_i2s_receiver.sv
// Scoreboard bench for i2s_receiver: drives Philips-I2S frames and compares
// every data_ready pair against the values queued when the frame was sent.
module tb_i2s_receiver;

    localparam bit WS_L = 1'b0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  sample_size = 3'd3;
    logic        i2s_sck = 1'b0;
    logic        i2s_ws = WS_L;
    logic        i2s_sd = 1'b0;
    logic [31:0] sample_left, sample_right;
    logic        data_ready, frame_error;

    int n_checks = 0;
    int n_errors = 0;
    int n_ready  = 0;
    logic [63:0] exp_q[$];
    logic [31:0] held_l = '0, held_r = '0;
    logic        prev_ready = 1'b0;

    i2s_receiver #(.SYNC_STAGES(2), .WS_LEFT_LEVEL(WS_L)) dut (
        .clk(clk), .rst(rst), .sample_size(sample_size),
        .i2s_sck(i2s_sck), .i2s_ws(i2s_ws), .i2s_sd(i2s_sd),
        .sample_left(sample_left), .sample_right(sample_right),
        .data_ready(data_ready), .frame_error(frame_error)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Output monitor / scoreboard
    always @(negedge clk) begin
        if (rst) begin
            prev_ready = 1'b0;
        end else begin
            if (data_ready) begin
                n_ready++;
                check_val("ready_width", {31'd0, prev_ready}, 32'd0);
                if (exp_q.size() == 0) begin
                    check_val("unexpected_ready", 32'd1, 32'd0);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    check_val("sample_left", sample_left, e[63:32]);
                    check_val("sample_right", sample_right, e[31:0]);
                end
            end else if (sample_left !== held_l || sample_right !== held_r) begin
                check_val("hold_left", sample_left, held_l);
                check_val("hold_right", sample_right, held_r);
            end
            prev_ready = data_ready;
        end
        held_l = sample_left;
        held_r = sample_right;
    end

    task automatic send_slot(input logic ws, input logic sd);
        i2s_ws = ws;
        i2s_sd = sd;
        #80 i2s_sck = 1'b1;
        #80 i2s_sck = 1'b0;
    endtask

    // pad: 0 zeros, 1 ones, 2 random
    task automatic send_word(input logic ws_lvl, input logic [31:0] data, input int n,
                             input int slots, input int first, input int pad);
        for (int i = first; i < slots; i++) begin
            logic b;
            if (i < n)         b = data[n-1-i];
            else if (pad == 0) b = 1'b0;
            else if (pad == 1) b = 1'b1;
            else               b = 1'($urandom);
            send_slot((i == slots - 1) ? ~ws_lvl : ws_lvl, b);
        end
    endtask

    task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int n,
                              input int slots, input int pad);
        send_word(WS_L, l, n, slots, 0, pad);
        send_word(~WS_L, r, n, slots, 0, pad);
    endtask

    task automatic push_frame(input logic [31:0] l, input logic [31:0] r, input int n,
                              input int slots, input int pad);
        exp_q.push_back({l, r});
        send_frame(l, r, n, slots, pad);
    endtask

    // Short right-channel tail ending in a left-going boundary
    task automatic preamble();
        send_word(~WS_L, $urandom, 16, 4, 0, 2);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk) rst = 1'b1;
        repeat (3) @(negedge clk);
        check_val({tag, "_rst_left"}, sample_left, 32'd0);
        check_val({tag, "_rst_right"}, sample_right, 32'd0);
        check_val({tag, "_rst_ready"}, {31'd0, data_ready}, 32'd0);
        check_val({tag, "_rst_ferr"}, {31'd0, frame_error}, 32'd0);
        exp_q.delete();
        rst = 1'b0;
        #3;
    endtask

    initial begin
        int base;
        logic [31:0] l, r;

        // Test 1: 16-bit, 16 SCK per channel
        do_reset("t1");
        sample_size = 3'd3;
        base = n_ready;
        preamble();
        push_frame(32'h0000A5C3, 32'h00001234, 16, 16, 0);
        repeat (4) @(negedge clk);
        check_val("t1_pulses", n_ready - base, 1);
        check_val("t1_ferr", {31'd0, frame_error}, 0);

        // Test 2: 24-bit in 32 slots, trailing ones ignored
        do_reset("t2");
        sample_size = 3'd4;
        preamble();
        push_frame(32'h00800001, 32'h007FFFFF, 24, 32, 1);
        repeat (4) @(negedge clk);
        check_val("t2_ferr", {31'd0, frame_error}, 0);

        // Test 3: short words flag error, size change recovers
        do_reset("t3");
        sample_size = 3'd4;
        base = n_ready;
        preamble();
        send_frame($urandom, $urandom, 16, 16, 0);
        check_val("t3_ferr_set", {31'd0, frame_error}, 1);
        check_val("t3_no_ready", n_ready - base, 0);
        sample_size = 3'd3;
        send_frame($urandom, $urandom, 16, 16, 0);
        check_val("t3_no_ready2", n_ready - base, 0);
        push_frame(32'h0000BEEF, 32'h00000F0F, 16, 16, 0);
        repeat (4) @(negedge clk);
        check_val("t3_recovered", n_ready - base, 1);
        check_val("t3_ferr_sticky", {31'd0, frame_error}, 1);

        // Test 4: start mid-frame after reset
        do_reset("t4");
        sample_size = 3'd3;
        base = n_ready;
        send_word(WS_L, $urandom, 16, 16, 11, 2);
        send_word(~WS_L, $urandom, 16, 16, 0, 2);
        check_val("t4_no_partial", n_ready - base, 0);
        push_frame(32'h00005A5A, 32'h0000C001, 16, 16, 0);
        repeat (4) @(negedge clk);
        check_val("t4_pulses", n_ready - base, 1);

        // Test 5: reset in the middle of a left word
        do_reset("t5");
        preamble();
        push_frame(32'h00001111, 32'h00002222, 16, 16, 0);
        l = 32'h00003333;
        send_word(WS_L, l, 16, 16, 8, 0);
        do_reset("t5mid");
        base = n_ready;
        send_word(WS_L, l, 16, 16, 8, 0);
        send_word(~WS_L, 32'h00004444, 16, 16, 0, 0);
        push_frame(32'h00000001, 32'h0000FFFE, 16, 16, 0);
        repeat (4) @(negedge clk);
        check_val("t5_pulses", n_ready - base, 1);

        // Test 6: eight back-to-back 8-bit frames in 32 slots
        do_reset("t6");
        sample_size = 3'd0;
        base = n_ready;
        preamble();
        for (int k = 0; k < 8; k++) begin
            l = {24'd0, 8'($urandom)};
            r = {24'd0, 8'($urandom)};
            push_frame(l, r, 8, 32, 2);
        end
        repeat (4) @(negedge clk);
        check_val("t6_pulses", n_ready - base, 8);
        check_val("t6_ferr", {31'd0, frame_error}, 0);

        // SCK stopped: outputs hold, no further pulses
        base = n_ready;
        repeat (40) @(negedge clk);
        check_val("idle_pulses", n_ready - base, 0);
        check_val("pending", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
